// File: rtl/pic_pm_pkg.sv
// Shared definitions for the program-memory arbiter: FSM encoding, NOP word
// and default bus widths.
package pic_pm_pkg;

  localparam int PM_ADDR_W = 11;
  localparam int PM_DATA_W = 14;

  localparam logic [PM_DATA_W-1:0] PM_NOP = 14'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PM_RD   = 2'd2,
    PM_HOLD = 2'd3
  } pm_state_t;

endpackage

// File: rtl/prog_mem_arbiter.sv
// Arbitrates the single program-ROM port between instruction fetch and
// PMCON1.RD reads. Optional address range check: define PM_RANGE_CHECK_EN.
module prog_mem_arbiter
  import pic_pm_pkg::*;
#(
  parameter int ADDR_W    = PM_ADDR_W,
  parameter int DATA_W    = PM_DATA_W,
  parameter int ROM_DEPTH = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              pm_rd_req,
  input  logic [ADDR_W-1:0] pm_addr,
  output logic              pm_busy,
  output logic              pm_done,
  output logic [DATA_W-1:0] pm_data,
  output logic              pm_ovr,
`ifdef PM_RANGE_CHECK_EN
  output logic              addr_err,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(PM_NOP);

  pm_state_t         state;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W-1:0] pm_addr_q;
  logic [DATA_W-1:0] rom_word;

  // rom_addr is combinational so a grant can read the ROM in the same cycle;
  // rom_addr_q keeps the last driven address for cycles with no owner.
  always_comb begin
    fetch_gnt = 1'b0;
    rom_addr  = rom_addr_q;
    unique case (state)
      IDLE, FETCH: begin
        if (fetch_req && !pm_rd_req) begin
          fetch_gnt = 1'b1;
          rom_addr  = fetch_addr;
        end
      end
      PM_RD:   rom_addr = pm_addr_q;
      PM_HOLD: rom_addr = rom_addr_q;
      default: rom_addr = rom_addr_q;
    endcase
  end

`ifdef PM_RANGE_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(ROM_DEPTH);

  logic rom_oob;

  always_comb begin
    rom_oob  = ({1'b0, rom_addr} >= DEPTH_LIM);
    rom_word = rom_oob ? NOP_WORD : rom_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err <= 1'b0;
    end else if (rom_oob && (fetch_gnt || state == PM_RD)) begin
      addr_err <= 1'b1;
    end
  end
`else
  always_comb begin
    rom_word = rom_data;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rom_addr_q  <= '0;
      pm_addr_q   <= '0;
      fetch_valid <= 1'b0;
      fetch_data  <= NOP_WORD;
      pm_busy     <= 1'b0;
      pm_done     <= 1'b0;
      pm_data     <= NOP_WORD;
      pm_ovr      <= 1'b0;
    end else begin
      rom_addr_q  <= rom_addr;
      fetch_valid <= fetch_gnt;
      pm_done     <= 1'b0;
      if (fetch_gnt) begin
        fetch_data <= rom_word;
      end
      unique case (state)
        IDLE, FETCH: begin
          if (pm_rd_req) begin
            pm_addr_q <= pm_addr;
            pm_busy   <= 1'b1;
            state     <= PM_RD;
          end else if (fetch_req) begin
            state <= FETCH;
          end else begin
            state <= IDLE;
          end
        end
        PM_RD: begin
          pm_data <= rom_word;
          pm_done <= 1'b1;
          state   <= PM_HOLD;
          if (pm_rd_req) begin
            pm_ovr <= 1'b1;
          end
        end
        PM_HOLD: begin
          pm_busy <= 1'b0;
          state   <= IDLE;
          if (pm_rd_req) begin
            pm_ovr <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
